// File: rtl/keypad_row_decoder.sv
// Receiver side of the 4x4 keypad scan: synchronizes row lines, resolves one key
// per full column scan and debounces presses/releases over DEBOUNCE_SCANS scans.
module keypad_row_decoder #(
  parameter int unsigned DEBOUNCE_SCANS = 5
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  input  logic [1:0] column_index,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 2;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  logic [ROW_W-1:0]  row_s1, row_s2;
  logic [COL_W-1:0]  col_d1, col_d2;
  logic              acc_hit;
  logic [CODE_W-1:0] acc_code;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] cand;

  logic              sample_hit;
  logic [CODE_W-1:0] sample_code;
  logic              scan_end;
  logic              scan_hit;
  logic [CODE_W-1:0] scan_key;
  logic              scan_match;
  logic [CNT_W-1:0]  cnt_inc;

  function automatic logic [1:0] lowest_row(input logic [ROW_W-1:0] rows);
    if (rows[0])      return 2'd0;
    else if (rows[1]) return 2'd1;
    else if (rows[2]) return 2'd2;
    else              return 2'd3;
  endfunction

  // Row synchronizer and matching column delay keep each sample tagged with its column.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      row_s1 <= '0;
      row_s2 <= '0;
      col_d1 <= '0;
      col_d2 <= '0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      col_d1 <= column_index;
      col_d2 <= col_d1;
    end
  end

  always_comb begin
    sample_hit  = |row_s2;
    sample_code = {lowest_row(row_s2), col_d2};
    scan_end    = (col_d2 == LAST_COL);
    scan_hit    = acc_hit | sample_hit;
    scan_key    = acc_hit ? acc_code : sample_code;
    scan_match  = scan_hit && (scan_key == cand);
    cnt_inc     = (cnt >= CNT_MAX) ? cnt : cnt + CNT_W'(1);
  end

  // First hit in a scan wins: lowest column, then lowest row.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      acc_hit  <= 1'b0;
      acc_code <= '0;
    end else if (scan_end) begin
      acc_hit  <= 1'b0;
      acc_code <= '0;
    end else if (!acc_hit && sample_hit) begin
      acc_hit  <= 1'b1;
      acc_code <= sample_code;
    end
  end

  // Debounce FSM, advanced once per completed scan.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cand        <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_end) begin
        case (state)
          ST_IDLE: begin
            if (scan_hit) begin
              cand <= scan_key;
              if (CNT_MAX == CNT_W'(1)) begin
                state       <= ST_PRESSED;
                cnt         <= '0;
                key_code    <= scan_key;
                key_valid   <= 1'b1;
                key_pressed <= 1'b1;
              end else begin
                state <= ST_DEBOUNCE;
                cnt   <= CNT_W'(1);
              end
            end
          end
          ST_DEBOUNCE: begin
            if (scan_match) begin
              cnt <= cnt_inc;
              if (cnt_inc >= CNT_MAX) begin
                state       <= ST_PRESSED;
                key_code    <= cand;
                key_valid   <= 1'b1;
                key_pressed <= 1'b1;
              end
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end
          ST_PRESSED: begin
            if (!scan_match) begin
              if (CNT_MAX == CNT_W'(1)) begin
                state       <= ST_IDLE;
                cnt         <= '0;
                key_pressed <= 1'b0;
              end else begin
                state <= ST_RELEASE;
                cnt   <= CNT_W'(1);
              end
            end
          end
          ST_RELEASE: begin
            if (scan_match) begin
              state <= ST_PRESSED;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc >= CNT_MAX) begin
                state       <= ST_IDLE;
                cnt         <= '0;
                key_pressed <= 1'b0;
              end
            end
          end
          default: begin
            state       <= ST_IDLE;
            cnt         <= '0;
            key_pressed <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_row_decoder.sv
// Directed bench for keypad_row_decoder: full column scans driven from a key mask,
// outputs sampled mid-scan where the previous scan's decision is visible.
module tb_keypad_row_decoder;

  logic       slow_clk;
  logic       rst;
  logic [3:0] row_in;
  logic [1:0] column_index;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  int vectors;
  int miscompares;
  int valid_pulses;
  logic       samp_valid;
  logic       samp_pressed;
  logic [3:0] samp_code;

  keypad_row_decoder #(.DEBOUNCE_SCANS(5)) dut (
    .slow_clk     (slow_clk),
    .rst          (rst),
    .row_in       (row_in),
    .column_index (column_index),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_pressed  (key_pressed)
  );

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  // One column per cycle; inputs change on the falling edge, away from sampling.
  task automatic drive_cycle(input logic [1:0] c, input logic [15:0] keys);
    logic [3:0] rows;
    @(negedge slow_clk);
    if (key_valid) valid_pulses++;
    if (c == 2'd2) begin
      samp_valid   = key_valid;
      samp_pressed = key_pressed;
      samp_code    = key_code;
    end
    for (int r = 0; r < 4; r++) rows[r] = keys[r*4 + int'(c)];
    column_index = c;
    row_in       = rows;
  endtask

  // keys bit {row,col} set = that key closed for the whole scan.
  task automatic do_scan(input logic [15:0] keys);
    for (int c = 0; c < 4; c++) drive_cycle(2'(c), keys);
  endtask

  task automatic apply_reset();
    @(negedge slow_clk);
    rst    = 1'b1;
    row_in = '0;
    #1;
    vectors++;
    if ({key_code, key_valid, key_pressed} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_async: code=%h valid=%b pressed=%b, want all 0", key_code, key_valid, key_pressed);
    end
    @(negedge slow_clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    row_in = '0;
    column_index = '0;
    repeat (2) @(negedge slow_clk);
    vectors++;
    if ({key_code, key_valid, key_pressed} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_state: code=%h valid=%b pressed=%b, want all 0", key_code, key_valid, key_pressed);
    end
    rst = 1'b0;
  endtask

  // Row1/col2 held 8 scans, then released; accept after 5th scan, drop 5 scans after release.
  task automatic test_single_press();
    int p0;
    logic [15:0] k;
    apply_reset();
    p0 = valid_pulses;
    k = 16'h0040;
    for (int i = 1; i <= 8; i++) begin
      do_scan(k);
      vectors++;
      if (samp_valid !== (i == 6) || samp_pressed !== (i >= 6)) begin
        miscompares++;
        $display("FAIL press_scan%0d: valid=%b pressed=%b, want %b %b", i, samp_valid, samp_pressed, (i == 6), (i >= 6));
      end
    end
    for (int r = 1; r <= 6; r++) begin
      do_scan(16'h0);
      vectors++;
      if (samp_pressed !== (r < 6)) begin
        miscompares++;
        $display("FAIL release_scan%0d: pressed=%b, want %b", r, samp_pressed, (r < 6));
      end
    end
    vectors++;
    if (key_code !== 4'h6 || valid_pulses - p0 != 1) begin
      miscompares++;
      $display("FAIL press_code: code=%h pulses=%0d, want 6 1", key_code, valid_pulses - p0);
    end
  endtask

  // Row3/col0 bouncing 2 scans on, 2 off: never reaches debounce.
  task automatic test_bounce();
    int p0;
    apply_reset();
    p0 = valid_pulses;
    for (int i = 0; i < 20; i++) begin
      do_scan(((i / 2) % 2 == 0) ? 16'h1000 : 16'h0000);
      vectors++;
      if (samp_pressed !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce_scan%0d: pressed=%b, want 0", i, samp_pressed);
      end
    end
    vectors++;
    if (valid_pulses - p0 != 0) begin
      miscompares++;
      $display("FAIL bounce_pulses: got %0d, want 0", valid_pulses - p0);
    end
  endtask

  // Short release gap is absorbed; a full release drops key_pressed.
  task automatic test_repress();
    int p0;
    apply_reset();
    p0 = valid_pulses;
    repeat (6) do_scan(16'h0002);
    for (int i = 0; i < 3; i++) begin
      do_scan(16'h0);
      vectors++;
      if (samp_pressed !== 1'b1) begin
        miscompares++;
        $display("FAIL gap_scan%0d: pressed=%b, want 1", i, samp_pressed);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_scan(16'h0002);
      vectors++;
      if (samp_pressed !== 1'b1 || samp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL repress_scan%0d: pressed=%b valid=%b, want 1 0", i, samp_pressed, samp_valid);
      end
    end
    for (int r = 1; r <= 6; r++) begin
      do_scan(16'h0);
      vectors++;
      if (samp_pressed !== (r < 6)) begin
        miscompares++;
        $display("FAIL repress_release%0d: pressed=%b, want %b", r, samp_pressed, (r < 6));
      end
    end
    vectors++;
    if (key_code !== 4'h1 || valid_pulses - p0 != 1) begin
      miscompares++;
      $display("FAIL repress_code: code=%h pulses=%0d, want 1 1", key_code, valid_pulses - p0);
    end
  endtask

  // Row0/col3 and row2/col1 together: lower column wins.
  task automatic test_priority();
    int p0;
    apply_reset();
    p0 = valid_pulses;
    repeat (7) do_scan(16'h0208);
    vectors++;
    if (key_code !== 4'h9 || valid_pulses - p0 != 1 || key_pressed !== 1'b1) begin
      miscompares++;
      $display("FAIL priority: code=%h pulses=%0d pressed=%b, want 9 1 1", key_code, valid_pulses - p0, key_pressed);
    end
  endtask

  // Reset during the third debounce scan restarts the count from scratch.
  task automatic test_reset_mid();
    int p0;
    apply_reset();
    p0 = valid_pulses;
    repeat (2) do_scan(16'h0400);
    drive_cycle(2'd0, 16'h0400);
    drive_cycle(2'd1, 16'h0400);
    apply_reset();
    for (int i = 1; i <= 6; i++) begin
      do_scan(16'h0400);
      vectors++;
      if (samp_valid !== (i == 6) || samp_pressed !== (i >= 6)) begin
        miscompares++;
        $display("FAIL rstmid_scan%0d: valid=%b pressed=%b, want %b %b", i, samp_valid, samp_pressed, (i == 6), (i >= 6));
      end
    end
    vectors++;
    if (key_code !== 4'hA || valid_pulses - p0 != 1) begin
      miscompares++;
      $display("FAIL rstmid_code: code=%h pulses=%0d, want a 1", key_code, valid_pulses - p0);
    end
  endtask

  // Key 5 switched directly to key B: full release, then full press debounce.
  task automatic test_back_to_back();
    int p0;
    apply_reset();
    repeat (6) do_scan(16'h0020);
    p0 = valid_pulses;
    for (int i = 1; i <= 11; i++) begin
      do_scan(16'h0800);
      vectors++;
      if (samp_pressed !== (i <= 5 || i >= 11) || samp_valid !== (i == 11) ||
          samp_code !== ((i >= 11) ? 4'hB : 4'h5)) begin
        miscompares++;
        $display("FAIL switch_scan%0d: pressed=%b valid=%b code=%h, want %b %b %h", i, samp_pressed,
                 samp_valid, samp_code, (i <= 5 || i >= 11), (i == 11), (i >= 11) ? 4'hB : 4'h5);
      end
    end
    vectors++;
    if (valid_pulses - p0 != 1) begin
      miscompares++;
      $display("FAIL switch_pulses: got %0d, want 1", valid_pulses - p0);
    end
    apply_reset();
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    valid_pulses = 0;
    samp_valid   = 1'b0;
    samp_pressed = 1'b0;
    samp_code    = '0;
    test_reset();
    test_single_press();
    test_bounce();
    test_repress();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
